vga_scan_driver: RTL and testbench

- Raster timing source and pixel output stage at the far end of the colour path.
- Generates DrawX/DrawY for the sprite, wall, food and text logic and for color_mapper.
- Registers the RGB that color_mapper returns and drives the VGA DAC pins with aligned sync and blank.
- Runs off the 50 MHz system clock using an internal divide-by-2 pixel enable, giving 640x480 at about 60 Hz.

---
 rtl/vga_scan_driver_if.sv | 33 +++
 rtl/vga_scan_driver.sv | 103 ++++++++++
 tb/tb_vga_scan_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_scan_driver_if.sv
// Pixel-side bundle between the raster driver, the colour path and the VGA DAC pins.
interface vga_scan_driver_if;
    logic [7:0] pix_R;
    logic [7:0] pix_G;
    logic [7:0] pix_B;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_start;

    modport master (
        input  pix_R, pix_G, pix_B,
        output DrawX, DrawY,
        output VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        output frame_start
    );

    modport slave (
        output pix_R, pix_G, pix_B,
        input  DrawX, DrawY,
        input  VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK,
        input  frame_start
    );
endinterface

// File: rtl/vga_scan_driver.sv
// Raster counters plus registered, blank-gated RGB/sync pin stage for a VGA DAC.
// Runs from the system clock with a divide-by-2 pixel enable that doubles as VGA_CLK.
module vga_scan_driver #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic Clk,
    input  logic Reset,
    vga_scan_driver_if.master vga
);

    localparam int unsigned CW           = 10;
    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic          pix_en;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          hsync;
    logic          vsync;
    logic          blank_n;
    logic          frame_pulse;

    logic vis_c;
    logic hs_c;
    logic vs_c;
    logic h_last_c;
    logic v_last_c;

    // Decode of the pixel currently addressed by hc/vc.
    always_comb begin
        vis_c    = (hc < CW'(H_VISIBLE)) && (vc < CW'(V_VISIBLE));
        hs_c     = !((hc >= CW'(H_SYNC_START)) && (hc <= CW'(H_SYNC_END)));
        vs_c     = !((vc >= CW'(V_SYNC_START)) && (vc <= CW'(V_SYNC_END)));
        h_last_c = (hc == CW'(H_TOTAL - 1));
        v_last_c = (vc == CW'(V_TOTAL - 1));
    end

    // Pins update on the tick edge, i.e. where VGA_CLK falls, so the DAC sees
    // settled data on the following VGA_CLK rise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            pix_en      <= !pix_en;
            frame_pulse <= 1'b0;
            if (pix_en) begin
                red     <= vis_c ? vga.pix_R : 8'h00;
                green   <= vis_c ? vga.pix_G : 8'h00;
                blue    <= vis_c ? vga.pix_B : 8'h00;
                blank_n <= vis_c;
                hsync   <= hs_c;
                vsync   <= vs_c;
                if (h_last_c) begin
                    hc <= '0;
                    if (v_last_c) begin
                        vc          <= '0;
                        frame_pulse <= 1'b1;
                    end else begin
                        vc <= vc + CW'(1);
                    end
                end else begin
                    hc <= hc + CW'(1);
                end
            end
        end
    end

    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.VGA_R       = red;
    assign vga.VGA_G       = green;
    assign vga.VGA_B       = blue;
    assign vga.VGA_HS      = hsync;
    assign vga.VGA_VS      = vsync;
    assign vga.VGA_BLANK_N = blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_CLK     = pix_en;
    assign vga.frame_start = frame_pulse;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver: full-width lines, a shortened frame height.
module tb_vga_scan_driver;

    localparam int unsigned HV = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HS = 96;
    localparam int unsigned HB = 48;
    localparam int unsigned VV = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank_n;
        logic       hs;
        logic       vs;
    } pins_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    vga_scan_driver_if vga ();

    vga_scan_driver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk  (clk),
        .Reset(reset),
        .vga  (vga)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    pins_t sb_q[$];
    pins_t held;

    int unsigned mhc = 0;
    int unsigned mvc = 0;
    bit          mpe = 1'b0;
    bit          mfs = 1'b0;

    int vis_cnt, blank_cnt, hs_low_cnt, vs_low_cnt, fs_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (hc=%0d vc=%0d t=%0t)", tag, got, exp, mhc, mvc, $time);
        end
    endtask

    // One Clk cycle: drive inputs, push the expected pin state for this edge,
    // advance the model, then compare everything half a cycle after the edge.
    task automatic run_cycle(input bit rst, input logic [23:0] pix);
        pins_t e;
        bit    tick;
        bit    vis;
        reset     = rst;
        vga.pix_R = pix[23:16];
        vga.pix_G = pix[15:8];
        vga.pix_B = pix[7:0];
        tick      = !rst && mpe;
        e         = '0;
        if (rst) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            sb_q.push_back(e);
        end else if (mpe) begin
            vis       = (mhc < HV) && (mvc < VV);
            e.r       = vis ? pix[23:16] : 8'h00;
            e.g       = vis ? pix[15:8]  : 8'h00;
            e.b       = vis ? pix[7:0]   : 8'h00;
            e.blank_n = vis;
            e.hs      = !((mhc >= HV + HF) && (mhc < HV + HF + HS));
            e.vs      = !((mvc >= VV + VF) && (mvc < VV + VF + VS));
            sb_q.push_back(e);
        end
        if (rst) begin
            mpe = 1'b0; mhc = 0; mvc = 0; mfs = 1'b0;
        end else begin
            mfs = mpe && (mhc == HT - 1) && (mvc == VT - 1);
            if (mpe) begin
                if (mhc == HT - 1) begin
                    mhc = 0;
                    mvc = (mvc == VT - 1) ? 0 : mvc + 1;
                end else begin
                    mhc = mhc + 1;
                end
            end
            mpe = !mpe;
        end
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) held = sb_q.pop_front();
        check_eq("DrawX",       32'(vga.DrawX),       32'(mhc));
        check_eq("DrawY",       32'(vga.DrawY),       32'(mvc));
        check_eq("VGA_CLK",     32'(vga.VGA_CLK),     32'(mpe));
        check_eq("frame_start", 32'(vga.frame_start), 32'(mfs));
        check_eq("SYNC_N",      32'(vga.VGA_SYNC_N),  32'(0));
        check_eq("VGA_R",       32'(vga.VGA_R),       32'(held.r));
        check_eq("VGA_G",       32'(vga.VGA_G),       32'(held.g));
        check_eq("VGA_B",       32'(vga.VGA_B),       32'(held.b));
        check_eq("BLANK_N",     32'(vga.VGA_BLANK_N), 32'(held.blank_n));
        check_eq("HS",          32'(vga.VGA_HS),      32'(held.hs));
        check_eq("VS",          32'(vga.VGA_VS),      32'(held.vs));
        if (vga.frame_start === 1'b1) fs_cnt++;
        if (tick) begin
            if (vga.VGA_BLANK_N === 1'b1 && {vga.VGA_R, vga.VGA_G, vga.VGA_B} === 24'hFF0080) vis_cnt++;
            if (vga.VGA_BLANK_N === 1'b0 && {vga.VGA_R, vga.VGA_G, vga.VGA_B} === 24'h000000) blank_cnt++;
            if (vga.VGA_HS === 1'b0) hs_low_cnt++;
            if (vga.VGA_VS === 1'b0) vs_low_cnt++;
        end
    endtask

    initial begin
        bit reached;
        int budget;
        vga.pix_R = 8'h00;
        vga.pix_G = 8'h00;
        vga.pix_B = 8'h00;

        // Power-on reset, then one full line of constant colour.
        repeat (3) run_cycle(1'b1, 24'h000000);
        vis_cnt = 0; blank_cnt = 0;
        repeat (2 * HT) run_cycle(1'b0, 24'hFF0080);
        check_eq("line_visible_ticks", 32'(vis_cnt),   32'(HV));
        check_eq("line_blank_ticks",   32'(blank_cnt), 32'(HT - HV));

        // Three whole frames of random colour.
        hs_low_cnt = 0; vs_low_cnt = 0; fs_cnt = 0;
        repeat (3 * VT * HT * 2) run_cycle(1'b0, 24'($urandom));
        check_eq("frame_start_pulses", 32'(fs_cnt),     32'(3));
        check_eq("hs_low_ticks",       32'(hs_low_cnt), 32'(3 * VT * HS));
        check_eq("vs_low_ticks",       32'(vs_low_cnt), 32'(3 * VS * HT));

        // Reset in the middle of a visible line, then resume.
        reached = 1'b0;
        budget  = 2 * VT * HT * 2;
        while (!reached && budget > 0) begin
            if (mhc == 300 && mvc == 2) reached = 1'b1;
            else run_cycle(1'b0, 24'($urandom));
            budget--;
        end
        check_eq("reach_mid_reset_point", 32'(reached), 32'(1));
        run_cycle(1'b1, 24'($urandom));
        vis_cnt = 0; blank_cnt = 0;
        repeat (2 * HT) run_cycle(1'b0, 24'hFF0080);
        check_eq("post_reset_visible_ticks", 32'(vis_cnt),   32'(HV));
        check_eq("post_reset_blank_ticks",   32'(blank_cnt), 32'(HT - HV));
        repeat (4 * HT) run_cycle(1'b0, 24'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
